// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial arithmetic blocks.
// The state encoding is shared with the serial adder so that both blocks
// present the same IDLE/RUN/DONE codes to debug and monitoring logic.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;

   // Bit counter must be able to hold WIDTH itself after the final RUN edge.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// -----------------------------------------------------------------------------
// half_subtractor / full_subtractor_cell
// Purely combinational one-bit subtraction cells.
//   half_subtractor      : a, b        -> d = a ^ b, bo = ~a & b
//   full_subtractor_cell : a, b, bin   -> d, bout
// The full cell chains two half subtractors (a - b, then - bin) and ORs
// their borrows; the two borrows can never both be set.
// -----------------------------------------------------------------------------
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bo
);
   assign d  = a ^ b;
   assign bo = ~a & b;
endmodule

module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;

   half_subtractor u_hs_ab (
      .a  (a),
      .b  (b),
      .d  (d1),
      .bo (b1)
   );

   half_subtractor u_hs_bin (
      .a  (d1),
      .b  (bin),
      .d  (d),
      .bo (b2)
   );

   assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor computing a - b LSB-first, one bit per clock.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active-low
//   in_valid  : operands a/b presented        in_ready  : ready for operands
//   a, b      : WIDTH-bit minuend/subtrahend
//   out_valid : diff/borrow valid              out_ready : consumer accepts
//   diff      : (a - b) mod 2^WIDTH            borrow    : 1 iff a < b
//   busy      : operation in RUN or DONE
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;
   logic             bit_d, bit_bout;

   full_subtractor_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (bin_q),
      .d    (bit_d),
      .bout (bit_bout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               bin_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Result bits enter at the MSB so that after WIDTH shifts the
            // first (LSB) difference bit has reached position 0.
            diff_d            = diff_q >> 1;
            diff_d[WIDTH-1]   = bit_d;
            a_d               = a_q >> 1;
            b_d               = b_q >> 1;
            bin_d             = bit_bout;
            cnt_d             = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               borrow_d = bit_bout;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   // Operand shift registers carry no control meaning; reset is not needed.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   // Handshake outputs depend on state only: no out_ready -> in_ready path.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed and random checks of serial_subtractor at WIDTH = 8, 1 and 16.
// Expected results are computed from the operands when they are accepted,
// queued, and compared when each instance hands a result over.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // WIDTH = 8 instance
   logic        in_valid8, in_ready8, out_valid8, out_ready8, borrow8, busy8;
   logic [7:0]  a8, b8, diff8;
   // WIDTH = 1 instance
   logic        in_valid1, in_ready1, out_valid1, out_ready1, borrow1, busy1;
   logic [0:0]  a1, b1, diff1;
   // WIDTH = 16 instance
   logic        in_valid16, in_ready16, out_valid16, out_ready16, borrow16, busy16;
   logic [15:0] a16, b16, diff16;

   logic [8:0]  q8[$];
   logic [1:0]  q1[$];
   logic [16:0] q16[$];

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .diff(diff8), .borrow(borrow8), .busy(busy8));

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .diff(diff1), .borrow(borrow1), .busy(busy1));

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
      .diff(diff16), .borrow(borrow16), .busy(busy16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: zero-extended subtraction; the extra top bit is the borrow.
   function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction
   function automatic logic [1:0] ref1(input logic [0:0] x, input logic [0:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction
   function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction

   // Inputs change 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: sample at the falling edge before the handshake edge.
   always @(negedge clk) begin
      if (rst_n && out_valid8 && out_ready8) begin
         chk("w8_result_pending", (q8.size() > 0), 1);
         if (q8.size() > 0) chk("w8_result", {borrow8, diff8}, q8.pop_front());
      end
      if (rst_n && out_valid1 && out_ready1) begin
         chk("w1_result_pending", (q1.size() > 0), 1);
         if (q1.size() > 0) chk("w1_result", {borrow1, diff1}, q1.pop_front());
      end
      if (rst_n && out_valid16 && out_ready16) begin
         chk("w16_result_pending", (q16.size() > 0), 1);
         if (q16.size() > 0) chk("w16_result", {borrow16, diff16}, q16.pop_front());
      end
   end

   task automatic start8(input logic [7:0] x, input logic [7:0] y);
      chk("w8_in_ready_before_accept", in_ready8, 1);
      a8 = x; b8 = y; in_valid8 = 1'b1;
      q8.push_back(ref8(x, y));
      tick();
      in_valid8 = 1'b0;
   endtask
   task automatic start1(input logic [0:0] x, input logic [0:0] y);
      a1 = x; b1 = y; in_valid1 = 1'b1;
      q1.push_back(ref1(x, y));
      tick();
      in_valid1 = 1'b0;
   endtask
   task automatic start16(input logic [15:0] x, input logic [15:0] y);
      a16 = x; b16 = y; in_valid16 = 1'b1;
      q16.push_back(ref16(x, y));
      tick();
      in_valid16 = 1'b0;
   endtask

   // Edges from accept to out_valid, bounded.
   task automatic wait8(output int k);
      k = 0;
      while (!out_valid8 && k < 40) begin tick(); k++; end
   endtask
   task automatic wait1(output int k);
      k = 0;
      while (!out_valid1 && k < 40) begin tick(); k++; end
   endtask
   task automatic wait16(output int k);
      k = 0;
      while (!out_valid16 && k < 40) begin tick(); k++; end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int last;
      int ghost;
      logic [7:0]  ra8, rb8;
      logic [15:0] ra16, rb16;
      logic [0:0]  ra1, rb1;

      rst_n = 1'b0;
      in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0;
      in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0;
      in_valid16 = 0; out_ready16 = 0; a16 = '0; b16 = '0;
      tick(); tick();

      // Reset state
      chk("rst_in_ready",  in_ready8,  1);
      chk("rst_out_valid", out_valid8, 0);
      chk("rst_busy",      busy8,      0);
      chk("rst_diff",      diff8,      0);
      chk("rst_borrow",    borrow8,    0);
      chk("rst_w16_diff",  diff16,     0);
      chk("rst_w1_ready",  in_ready1,  1);
      rst_n = 1'b1;
      out_ready8 = 1'b1; out_ready1 = 1'b1; out_ready16 = 1'b1;
      tick();

      // 1: basic subtraction with latency check
      start8(8'h5A, 8'h3C);
      chk("t1_busy_run", busy8, 1);
      wait8(k);
      chk("t1_latency", k, 8);
      chk("t1_diff",   diff8,   8'h1E);
      chk("t1_borrow", borrow8, 0);
      tick();
      chk("t1_back_idle", in_ready8, 1);

      // 2: full borrow ripple
      start8(8'h00, 8'h01);
      wait8(k);
      chk("t2_latency", k, 8);
      chk("t2_diff",   diff8,   8'hFF);
      chk("t2_borrow", borrow8, 1);
      tick();

      // 3: back-pressure; result held, new operand not captured
      out_ready8 = 1'b0;
      start8(8'hA5, 8'hA5);
      wait8(k);
      chk("t3_latency", k, 8);
      a8 = 8'h11; b8 = 8'h00; in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_diff",      diff8,      0);
         chk("t3_hold_borrow",    borrow8,    0);
         chk("t3_hold_out_valid", out_valid8, 1);
         chk("t3_hold_in_ready",  in_ready8,  0);
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      tick();
      chk("t3_release_in_ready",  in_ready8,  1);
      chk("t3_release_out_valid", out_valid8, 0);
      chk("t3_retain_diff",       diff8,      0);

      // 4: reset during RUN at cnt=3 drops the operation
      start8(8'h33, 8'h11);
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      void'(q8.pop_back());
      chk("t4_in_ready",  in_ready8,  1);
      chk("t4_busy",      busy8,      0);
      chk("t4_out_valid", out_valid8, 0);
      ghost = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid8) ghost++;
      end
      chk("t4_no_ghost_result", ghost, 0);
      start8(8'h80, 8'h7F);
      wait8(k);
      chk("t4_latency", k, 8);
      chk("t4_diff",   diff8,   8'h01);
      chk("t4_borrow", borrow8, 0);
      tick();

      // 5: in_valid held high, operands changing every cycle
      last = -1;
      in_valid8 = 1'b1;
      for (int c = 0; c < 50; c++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom);
         a8 = ra8; b8 = rb8;
         if (in_ready8) begin
            q8.push_back(ref8(ra8, rb8));
            if (last >= 0) chk("t5_issue_interval", c - last, 10);
            last = c;
         end
         tick();
      end
      in_valid8 = 1'b0;
      k = 0;
      while (q8.size() > 0 && k < 30) begin tick(); k++; end
      chk("t5_drained", q8.size(), 0);

      // 6: WIDTH=1 and WIDTH=16 directed then random
      start1(1'b0, 1'b1);
      wait1(k);
      chk("w1_latency", k, 1);
      chk("w1_diff",   diff1,   1);
      chk("w1_borrow", borrow1, 1);
      tick();
      start16(16'h1234, 16'h4321);
      wait16(k);
      chk("w16_latency", k, 16);
      chk("w16_diff",   diff16,   16'hCF13);
      chk("w16_borrow", borrow16, 1);
      tick();
      for (int n = 0; n < 1000; n++) begin
         ra1 = 1'($urandom); rb1 = 1'($urandom);
         start1(ra1, rb1);
         wait1(k);
         tick();
      end
      for (int n = 0; n < 1000; n++) begin
         ra16 = 16'($urandom); rb16 = 16'($urandom);
         if (n % 100 == 0) begin ra16 = 16'h0000; rb16 = 16'hFFFF; end
         if (n % 100 == 1) rb16 = ra16;
         start16(ra16, rb16);
         wait16(k);
         if (n % 100 == 0) chk("w16_rand_latency", k, 16);
         tick();
      end

      chk("w8_queue_empty",  q8.size(),  0);
      chk("w1_queue_empty",  q1.size(),  0);
      chk("w16_queue_empty", q16.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes a - b LSB-first, one bit per clock.
- Returns the difference and the final borrow over a second valid/ready handshake.
- It is the inverse-operation companion to the adder cells, for area-constrained datapaths where a ripple subtractor is too wide.
- Built from a registered borrow and a full-subtractor cell composed of two half subtractors.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands a/b presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  final borrow out; 1 iff a < b (unsigned)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: sampled only on a rising clk edge with rst_n low (synchronous, active-low).
  - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, borrow=0, borrow register=0, bit counter=0.
  - Reset asserted mid-operation drops the in-flight operation; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, load a/b into shift registers, clear the borrow register and counter, go to RUN. a/b are sampled only at this accept edge.
  - RUN: in_ready=0. Each edge processes operand bit[cnt]:
    - d = a_i ^ b_i ^ bin
    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
    - d shifts into the MSB of the diff shift register; bout is stored; operands shift right; cnt++.
    - After the WIDTH-th RUN edge, go to DONE. Set out_valid=1 and borrow = last bout.
  - DONE: out_valid=1, in_ready=0. diff and borrow are held stable until the out_valid && out_ready edge, which returns to IDLE with out_valid=0.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. Minimum issue interval is WIDTH+2 cycles.
- Handshake timing:
  - in_ready is a function of state only; there is no combinational path from out_ready to in_ready.
  - A new operand cannot be accepted on the same edge as the result handshake.
- in_valid during RUN/DONE is ignored; the operand is not captured, and the source must hold it until in_ready.
- out_ready while not in DONE has no effect.
- diff is meaningful only while out_valid=1. During RUN it holds partial shift contents; the verifier must not check it then.
- After the output handshake, diff and borrow retain their last values until the next operation completes.
- Counter width is $clog2(WIDTH)+1. WIDTH=1 takes exactly one RUN cycle.
- Boundaries:
  - a=b gives diff=0, borrow=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
  - Borrow ripples across all bits with no overflow special case.

Decomposition:
- Shared package/include: state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2. Reused by the upcoming serial adder.
- Sub-module full_subtractor_cell(d, bout, a, b, bin): two half_subtractor instances plus an OR gate. It is purely combinational and instantiated once.

Test Plan:
1. WIDTH=8: a=0x5A, b=0x3C, in_valid for one cycle while in_ready=1 -> out_valid exactly 8 edges later; diff=0x1E, borrow=0.
2. a=0x00, b=0x01 -> diff=0xFF, borrow=1 (full borrow ripple through all 8 bits).
3. a=b=0xA5, out_ready held low 5 cycles after out_valid -> diff=0x00, borrow=0 stable throughout. in_ready=0 and an in_valid with a=0x11 is not captured. Release out_ready -> IDLE next edge.
4. Drive rst_n low for one edge during RUN at cnt=3 -> next cycle in_ready=1, busy=0, out_valid=0, and no result is ever emitted. Then a=0x80, b=0x7F -> diff=0x01, borrow=0.
5. out_ready tied high, in_valid held high with changing operands -> accepts spaced exactly WIDTH+2 cycles apart; each result matches the operands present at its own accept edge.
6. Builds with WIDTH=1 and WIDTH=16, 1000 random operations against a reference model. WIDTH=1: a=0, b=1 -> diff=1, borrow=1 after 1 edge. WIDTH=16: a=0x1234, b=0x4321 -> diff=0xCF13, borrow=1.
